mips_mc_control: RTL and testbench

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_pkg.sv | 68 ++++++
 rtl/mips_alu_decoder.sv | 41 ++++
 rtl/mips_mc_control.sv | 173 +++++++++++++++++
 tb/tb_mips_mc_control.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_pkg
// Purpose  : Shared definitions for the multicycle MIPS control path: FSM
//            state encoding, opcode/funct fields, ALU operation codes and
//            datapath mux select codes. The ALU operation codes here are the
//            single source used by both the control FSM and the datapath ALU.
// Revision : 1.0 - initial release
// ============================================================================
package mips_mc_pkg;

    // Controller states; the 4-bit encoding is visible on the debug port.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;
    localparam logic [5:0] c_FN_DIV = 6'b011010;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_DIV = 4'b1010;

    // ALU operand A select
    localparam logic       c_ALUA_PC   = 1'b0;
    localparam logic       c_ALUA_REGA = 1'b1;

    // ALU operand B select
    localparam logic [1:0] c_ALUB_REGB  = 2'b00;
    localparam logic [1:0] c_ALUB_FOUR  = 2'b01;
    localparam logic [1:0] c_ALUB_IMM   = 2'b10;
    localparam logic [1:0] c_ALUB_IMMSH = 2'b11;

    // Next-PC select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

endpackage : mips_mc_pkg
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_decoder
// Purpose  : Maps an R-type funct field to an ALU operation code and flags
//            unsupported funct values. DIV is accepted only when DIV_EN=1.
//            Unsupported functs produce operation code 0000.
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_decoder
    import mips_mc_pkg::*;
#(
    parameter bit DIV_EN = 1'b1
) (
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control,
    output logic       o_illegal
);

    // Pure table lookup from funct to ALU operation plus illegal flag
    always_comb begin
        o_alu_control = c_ALU_AND;
        o_illegal     = 1'b0;
        case (i_funct)
            c_FN_ADD: o_alu_control = c_ALU_ADD;
            c_FN_SUB: o_alu_control = c_ALU_SUB;
            c_FN_AND: o_alu_control = c_ALU_AND;
            c_FN_OR:  o_alu_control = c_ALU_OR;
            c_FN_SLT: o_alu_control = c_ALU_SLT;
            c_FN_DIV: begin
                if (DIV_EN) begin
                    o_alu_control = c_ALU_DIV;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule : mips_alu_decoder
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_control
// Purpose  : Multicycle MIPS controller. Moore FSM driving datapath selects
//            and strobes from the current state; the PC enable additionally
//            folds in the ALU zero flag for branches. Write strobes, PC
//            enable and the illegal pulse are held low while reset is high.
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter bit DIV_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_next;

    logic [3:0] w_fn_alu;
    logic       w_fn_illegal;

    logic       w_pc_write;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_illegal;

    mips_alu_decoder #(
        .DIV_EN (DIV_EN)
    ) u_alu_decoder (
        .i_funct       (funct),
        .o_alu_control (w_fn_alu),
        .o_illegal     (w_fn_illegal)
    );

    // State register; reset always lands in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode; unknown encodings fall back to FETCH
    always_comb begin
        w_next      = S_FETCH;
        alu_control = c_ALU_AND;
        alu_src_a   = c_ALUA_PC;
        alu_src_b   = c_ALUB_REGB;
        pc_src      = c_PCSRC_ALU;
        i_or_d      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                alu_src_b   = c_ALUB_FOUR;
                alu_control = c_ALU_ADD;
                w_pc_write  = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target in case this is a beq
                alu_src_b   = c_ALUB_IMMSH;
                alu_control = c_ALU_ADD;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEXEC;
                    c_OP_J:           w_next = S_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = c_ALUA_REGA;
                alu_src_b   = c_ALUB_IMM;
                alu_control = c_ALU_ADD;
                w_next      = (opcode == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                i_or_d = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                i_or_d      = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECUTE: begin
                alu_src_a   = c_ALUA_REGA;
                alu_control = w_fn_alu;
                w_illegal   = w_fn_illegal;
                w_next      = w_fn_illegal ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = c_ALUA_REGA;
                alu_control = c_ALU_SUB;
                pc_src      = c_PCSRC_ALUOUT;
                w_branch    = 1'b1;
                w_next      = S_FETCH;
            end
            S_ADDIEXEC: begin
                alu_src_a   = c_ALUA_REGA;
                alu_src_b   = c_ALUB_IMM;
                alu_control = c_ALU_ADD;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = c_PCSRC_JUMP;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Side-effecting strobes are suppressed for the whole reset cycle
    assign pc_en     = ~reset & (w_pc_write | (w_branch & zero));
    assign ir_write  = ~reset & w_ir_write;
    assign mem_write = ~reset & w_mem_write;
    assign reg_write = ~reset & w_reg_write;
    assign illegal   = ~reset & w_illegal;
    assign state     = r_state;

endmodule : mips_mc_control
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_control
// Purpose  : Self-checking bench for mips_mc_control. Two instances (DIV
//            enabled / disabled) share stimulus. A behavioural model tracks
//            each instance's position within the current instruction and
//            derives the expected outputs from the instruction's state list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;
    import mips_mc_pkg::*;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4,
                   K_J = 5, K_BADOP = 6, K_BADFN = 7;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;

    logic [3:0] alu1, alu0, st1, st0;
    logic       sa1, sa0, pe1, pe0, iod1, iod0, irw1, irw0, mw1, mw0;
    logic       rw1, rw0, rd1, rd0, m2r1, m2r0, ill1, ill0;
    logic [1:0] sb1, sb0, ps1, ps0;

    int checks   = 0;
    int failures = 0;
    int pos1     = 0;
    int pos0     = 0;
    bit started  = 1'b0;

    mips_mc_control #(.DIV_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(alu1), .alu_src_a(sa1), .alu_src_b(sb1), .pc_src(ps1),
        .pc_en(pe1), .i_or_d(iod1), .ir_write(irw1), .mem_write(mw1),
        .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1), .illegal(ill1),
        .state(st1)
    );

    mips_mc_control #(.DIV_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(alu0), .alu_src_a(sa0), .alu_src_b(sb0), .pc_src(ps0),
        .pc_en(pe0), .i_or_d(iod0), .ir_write(irw0), .mem_write(mw0),
        .reg_write(rw0), .reg_dst(rd0), .mem_to_reg(m2r0), .illegal(ill0),
        .state(st0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] fn_alu(input logic [5:0] fn, input bit de);
        case (fn)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b011010: return de ? 4'b1010 : 4'b0000;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] fn, input bit de);
        return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
               (fn == 6'b100101) || (fn == 6'b101010) ||
               (de && fn == 6'b011010);
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input bit de);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return fn_ok(fn, de) ? K_R : K_BADFN;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_BADOP;
        endcase
    endfunction

    function automatic int ilen(input int k);
        case (k)
            K_LW:                 return 5;
            K_SW, K_R, K_ADDI:    return 4;
            K_BEQ, K_J, K_BADFN:  return 3;
            default:              return 2;
        endcase
    endfunction

    function automatic state_t state_at(input int k, input int pos);
        if (pos == 0) return S_FETCH;
        if (pos == 1) return S_DECODE;
        case (k)
            K_LW:    return (pos == 2) ? S_MEMADR : ((pos == 3) ? S_MEMREAD : S_MEMWB);
            K_SW:    return (pos == 2) ? S_MEMADR : S_MEMWRITE;
            K_R:     return (pos == 2) ? S_EXECUTE : S_ALUWB;
            K_BADFN: return S_EXECUTE;
            K_BEQ:   return S_BRANCH;
            K_ADDI:  return (pos == 2) ? S_ADDIEXEC : S_ADDIWB;
            K_J:     return S_JUMP;
            default: return S_FETCH;
        endcase
    endfunction

    // {alu4, srca, srcb2, pcsrc2, pc_en, iord, irw, mw, rw, rdst, m2r, ill, state4}
    function automatic logic [20:0] expv(input int pos, input bit de, input logic rst,
                                         input logic z, input logic [5:0] op,
                                         input logic [5:0] fn);
        int         k;
        state_t     s;
        logic [3:0] alu;
        logic       sa, pe, pw, br, iod, irw, mw, rw, rd, m2r, ill;
        logic [1:0] sb, ps;
        k   = classify(op, fn, de);
        s   = state_at(k, pos);
        alu = 4'b0000; sa = 1'b0; sb = 2'b00; ps = 2'b00;
        pw = 1'b0; br = 1'b0; iod = 1'b0; irw = 1'b0; mw = 1'b0;
        rw = 1'b0; rd = 1'b0; m2r = 1'b0; ill = 1'b0;
        case (s)
            S_FETCH:    begin irw = 1'b1; sb = 2'b01; alu = 4'b0010; pw = 1'b1; end
            S_DECODE:   begin sb = 2'b11; alu = 4'b0010; ill = (k == K_BADOP); end
            S_MEMADR:   begin sa = 1'b1; sb = 2'b10; alu = 4'b0010; end
            S_MEMREAD:  begin iod = 1'b1; end
            S_MEMWB:    begin m2r = 1'b1; rw = 1'b1; end
            S_MEMWRITE: begin iod = 1'b1; mw = 1'b1; end
            S_EXECUTE:  begin sa = 1'b1; alu = fn_alu(fn, de); ill = (k == K_BADFN); end
            S_ALUWB:    begin rd = 1'b1; rw = 1'b1; end
            S_BRANCH:   begin sa = 1'b1; alu = 4'b0110; ps = 2'b01; br = 1'b1; end
            S_ADDIEXEC: begin sa = 1'b1; sb = 2'b10; alu = 4'b0010; end
            S_ADDIWB:   begin rw = 1'b1; end
            S_JUMP:     begin ps = 2'b10; pw = 1'b1; end
            default:    begin end
        endcase
        pe = pw | (br & z);
        if (rst) begin
            pe = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; ill = 1'b0;
        end
        return {alu, sa, sb, ps, pe, iod, irw, mw, rw, rd, m2r, ill, 4'(s)};
    endfunction

    function automatic int advance(input int pos, input bit de);
        int n;
        if (reset) return 0;
        n = pos + 1;
        if (n >= ilen(classify(opcode, funct, de))) n = 0;
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (started) begin
            chk("dut1_outputs",
                {alu1, sa1, sb1, ps1, pe1, iod1, irw1, mw1, rw1, rd1, m2r1, ill1, st1},
                expv(pos1, 1'b1, reset, zero, opcode, funct));
            chk("dut0_outputs",
                {alu0, sa0, sb0, ps0, pe0, iod0, irw0, mw0, rw0, rd0, m2r0, ill0, st0},
                expv(pos0, 1'b0, reset, zero, opcode, funct));
        end
    end

    // One clock: model advances on the edge, then new reset/zero are driven
    task automatic tick(input logic r, input logic z);
        @(posedge clk);
        pos1 = advance(pos1, 1'b1);
        pos0 = advance(pos0, 1'b0);
        started = 1'b1;
        #1;
        reset = r;
        zero  = z;
    endtask

    task automatic pick_instr();
        logic [5:0] fns [6];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011010};
        case ($urandom_range(0, 7))
            0: opcode = 6'b100011;
            1: opcode = 6'b101011;
            2, 3: opcode = 6'b000000;
            4: opcode = 6'b000100;
            5: opcode = 6'b001000;
            6: opcode = 6'b000010;
            default: opcode = 6'($urandom_range(0, 63));
        endcase
        if ($urandom_range(0, 4) == 0) funct = 6'($urandom_range(0, 63));
        else funct = fns[$urandom_range(0, 5)];
    endtask

    initial begin
        reset  = 1'b1;
        zero   = 1'b0;
        opcode = 6'b100011;
        funct  = 6'b100000;

        // Reset then lw
        tick(1'b1, 1'b0);
        #3 chk("reset_state", st1, S_FETCH);
        chk("reset_strobes", {pe1, irw1, mw1, rw1, ill1}, 5'b00000);
        tick(1'b0, 1'b0);
        #3 chk("lw_fetch", {st1, irw1, pe1}, {4'(S_FETCH), 2'b11});
        tick(1'b0, 1'b0);
        #3 chk("lw_decode", st1, S_DECODE);
        tick(1'b0, 1'b0);
        #3 chk("lw_memadr", {st1, rw1, m2r1}, {4'(S_MEMADR), 2'b00});
        tick(1'b0, 1'b0);
        #3 chk("lw_memread", {st1, iod1, rw1}, {4'(S_MEMREAD), 2'b10});
        tick(1'b0, 1'b0);
        #3 chk("lw_memwb", {st1, rw1, m2r1}, {4'(S_MEMWB), 2'b11});

        // R-type sub
        tick(1'b0, 1'b0);
        opcode = 6'b000000; funct = 6'b100010;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #3 chk("sub_execute", {st1, alu1}, {4'(S_EXECUTE), 4'b0110});
        tick(1'b0, 1'b0);
        #3 chk("sub_aluwb", {st1, rw1, rd1}, {4'(S_ALUWB), 2'b11});
        tick(1'b0, 1'b0);
        #3 chk("sub_back_fetch", st1, S_FETCH);

        // beq taken then not taken
        opcode = 6'b000100;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        #3 chk("beq_taken", {st1, pe1, ps1}, {4'(S_BRANCH), 3'b101});
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #3 chk("beq_not_taken", {st1, pe1, ps1}, {4'(S_BRANCH), 3'b001});

        // Illegal opcode
        tick(1'b0, 1'b0);
        opcode = 6'b111111;
        tick(1'b0, 1'b0);
        #3 chk("badop_decode", {st1, ill1, pe1, mw1, rw1}, {4'(S_DECODE), 4'b1000});
        tick(1'b0, 1'b0);
        #3 chk("badop_fetch", st1, S_FETCH);

        // DIV: legal on dut1, illegal on dut0
        opcode = 6'b000000; funct = 6'b011010;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #3 chk("div0_execute", {st0, ill0, rw0}, {4'(S_EXECUTE), 2'b10});
        chk("div1_execute", {st1, alu1, ill1}, {4'(S_EXECUTE), 4'b1010, 1'b0});
        tick(1'b0, 1'b0);
        #3 chk("div0_no_aluwb", {st0, rw0}, {4'(S_FETCH), 1'b0});
        chk("div1_aluwb", st1, S_ALUWB);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // sw with reset raised during MEMWRITE
        opcode = 6'b101011;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        #3 chk("sw_reset_memwrite", {st1, mw1, iod1}, {4'(S_MEMWRITE), 2'b01});
        tick(1'b0, 1'b0);
        #3 chk("sw_reset_to_fetch", {st1, irw1}, {4'(S_FETCH), 1'b1});

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
            if (pos1 == 0 && pos0 == 0) pick_instr();
        end
        tick(1'b0, 1'b0);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mips_mc_control
`default_nettype wire
